toy_phy_reg_freelist: RTL
=========================

Name: toy_phy_reg_freelist

Overview:
Physical-register free list and pre-allocator. It is the supplier end of the pre-allocate handshake driven by the dispatch/issue stage.
- Presents one registered free physical-register ID per decode lane (vld/id).
- Consumes per-lane rdy from dispatch.
- Recycles IDs released by commit.
- One instance serves the integer file and one serves the FP file.

Parameters:
INST_DECODE_NUM, 4, decode/dispatch lanes (allocation slots)
RELEASE_NUM, 4, commit release ports per cycle
PHY_REG_NUM, 64, physical registers in the file
ARCH_REG_NUM, 32, architectural registers; IDs 0..ARCH_REG_NUM-1 mapped at reset, never in list at reset
PHY_REG_ID_WIDTH, 6, $clog2(PHY_REG_NUM)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
v_pre_allocate_vld  out  INST_DECODE_NUM  slot i holds a valid free ID
v_pre_allocate_id  out  PHY_REG_ID_WIDTH x INST_DECODE_NUM  ID in slot i
v_pre_allocate_rdy  in  INST_DECODE_NUM  lane i consumes slot i this cycle
v_pre_allocate_zero  in  INST_DECODE_NUM  lane i's rd is x0; consumption suppressed
v_release_vld  in  RELEASE_NUM  commit frees an ID
v_release_id  in  PHY_REG_ID_WIDTH x RELEASE_NUM  freed ID
free_cnt  out  PHY_REG_ID_WIDTH+1  IDs in FIFO (excluding slots)
freelist_err  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Storage:
  - Circular FIFO, depth FL_DEPTH = PHY_REG_NUM-ARCH_REG_NUM.
  - Head/tail pointers with an extra wrap bit.
  - Per-lane slot registers slot_vld/slot_id drive the vld/id outputs directly (no combinational path from rdy to vld/id).
- Reset:
  - FIFO entry k = ARCH_REG_NUM+k; head=0; tail wraps to head with wrap bit set (full).
  - free_cnt=FL_DEPTH.
  - All v_pre_allocate_vld=0; v_pre_allocate_id=0; freelist_err=0.
- Consume: slot i is consumed when slot_vld[i] & v_pre_allocate_rdy[i] & ~v_pre_allocate_zero[i].
  - rdy with zero=1 leaves the slot and its ID intact.
  - rdy on an invalid slot is ignored.
- Refill, per cycle:
  - Slot i needs fill if ~slot_vld[i] or it is consumed this cycle.
  - Needing slots, in ascending lane order, take consecutive entries from head.
  - The number filled is min(needing, free_cnt), using free_cnt before this cycle's releases.
  - Lanes beyond that count become/stay invalid.
  - New vld/id visible next cycle, i.e. consume-to-refill latency 1, back-to-back consumption every cycle at full rate.
  - First valid slots appear 1 cycle after reset deassertion.
- Release:
  - Valid release ports are compacted in ascending port order and written at tail.
  - Up to RELEASE_NUM per cycle; non-contiguous vld allowed.
  - Released IDs are refill-eligible from the next cycle (no same-cycle bypass).
- Count: free_cnt_next = free_cnt - filled + released, with pointers modulo FL_DEPTH.
  - FL_DEPTH need not be a power of 2; pointers wrap explicitly.
- Errors (set freelist_err, sticky until reset):
  - release that would exceed FL_DEPTH: excess releases dropped;
  - release of an ID < ARCH_REG_NUM never occurs legally; treated as error only when checking is enabled (see Optional Feature).
- Simultaneous fill and release with FIFO empty: fill sees 0 and slots stay invalid; released IDs are enqueued and appear next cycle.
- Conservation invariant: free_cnt + popcount(slot_vld) + in-flight IDs = FL_DEPTH.

Optional Feature:
TOY_FREELIST_CHECK_EN:
- Defined:
  - Keep a PHY_REG_NUM-bit "free" bitmap: set at reset for IDs >= ARCH_REG_NUM, cleared on fill, set on release.
  - Releasing an ID whose bit is already set (double free), or two ports releasing the same ID in one cycle, sets freelist_err; that ID is not enqueued.
- Undefined: no bitmap; only the overflow error is detected.

Decomposition:
- toy_pack: FL_DEPTH derivation, fl_ptr_t (index plus wrap bit), phy_reg_id_t.
- One sub-module, toy_freelist_compact: generic prefix-popcount lane compactor. It produces per-lane offsets and a total count, and is used twice (refill lane order, release port order).

Test Plan:
- Reset then idle 1 cycle -> vld=4'b1111, ids 32,33,34,35; free_cnt=28.
- Lanes 0 and 2 rdy=1 for one cycle -> next cycle slot0=36, slot2=37, slots 1 and 3 unchanged; free_cnt=26.
- rdy=4'b1111 with zero=4'b0010 -> slot1 keeps ID 33; slots 0, 2 and 3 refill with 36, 37, 38.
- Drain all 32 IDs, then release IDs 40,41 on ports 1 and 3 in the same cycle as a consume -> no refill that cycle; next cycle slots refill 40 then 41 in ascending lane order; freelist_err=0.
- With the FIFO full, release one ID -> freelist_err=1, free_cnt stays 28.
- With TOY_FREELIST_CHECK_EN defined, release ID 50 while it is still free -> freelist_err=1, free_cnt unchanged.

Source files
------------

// File: rtl/toy_phy_reg_freelist_pkg.sv
// toy_phy_reg_freelist_pkg: sizing, ID/pointer types and the wrapping pointer
// adder shared by the physical-register free list.
package toy_phy_reg_freelist_pkg;

    localparam int INST_DECODE_NUM  = 4;
    localparam int RELEASE_NUM      = 4;
    localparam int PHY_REG_NUM      = 64;
    localparam int ARCH_REG_NUM     = 32;
    localparam int PHY_REG_ID_WIDTH = $clog2(PHY_REG_NUM);
    localparam int FL_DEPTH         = PHY_REG_NUM - ARCH_REG_NUM;
    localparam int FL_IDX_W         = $clog2(FL_DEPTH);
    localparam int CNT_W            = PHY_REG_ID_WIDTH + 1;
    localparam int LANE_CNT_W       = $clog2(INST_DECODE_NUM + 1);
    localparam int REL_CNT_W        = $clog2(RELEASE_NUM + 1);

    typedef logic [PHY_REG_ID_WIDTH-1:0] phy_reg_id_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef struct packed {
        logic                wrap;
        logic [FL_IDX_W-1:0] idx;
    } fl_ptr_t;

    localparam cnt_t        FL_DEPTH_C = cnt_t'(FL_DEPTH);
    localparam phy_reg_id_t ARCH_ID    = phy_reg_id_t'(ARCH_REG_NUM);

    // Depth need not be a power of two, so the index wraps explicitly; n <= FL_DEPTH.
    function automatic fl_ptr_t ptr_add(input fl_ptr_t p, input cnt_t n);
        cnt_t    s;
        fl_ptr_t r;
        s      = cnt_t'(p.idx) + n;
        r.wrap = p.wrap ^ (s >= FL_DEPTH_C);
        r.idx  = (s >= FL_DEPTH_C) ? FL_IDX_W'(s - FL_DEPTH_C) : FL_IDX_W'(s);
        return r;
    endfunction

endpackage

// File: rtl/toy_phy_reg_freelist_compact.sv
// toy_phy_reg_freelist_compact: prefix-popcount compactor giving each request
// its rank among lower-numbered requests, plus the total request count.
module toy_phy_reg_freelist_compact #(
    parameter int N = 4,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0]        req,
    output logic [N-1:0][W-1:0] off,
    output logic [W-1:0]        cnt
);

    logic [W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            off[i] = acc;
            acc    = acc + W'(req[i]);
        end
        cnt = acc;
    end

endmodule

// File: rtl/toy_phy_reg_freelist.sv
// toy_phy_reg_freelist: physical-register free list with per-lane pre-allocate slots.
// Define TOY_FREELIST_CHECK_EN to add the free bitmap (double-free/duplicate/arch-ID checks).
module toy_phy_reg_freelist
    import toy_phy_reg_freelist_pkg::*;
(
    input  logic                                              clk,
    input  logic                                              rst,
    output logic [INST_DECODE_NUM-1:0]                        v_pre_allocate_vld,
    output logic [INST_DECODE_NUM-1:0][PHY_REG_ID_WIDTH-1:0]  v_pre_allocate_id,
    input  logic [INST_DECODE_NUM-1:0]                        v_pre_allocate_rdy,
    input  logic [INST_DECODE_NUM-1:0]                        v_pre_allocate_zero,
    input  logic [RELEASE_NUM-1:0]                            v_release_vld,
    input  logic [RELEASE_NUM-1:0][PHY_REG_ID_WIDTH-1:0]      v_release_id,
    output logic [PHY_REG_ID_WIDTH:0]                         free_cnt,
    output logic                                              freelist_err
);

    phy_reg_id_t                          fifo [FL_DEPTH];
    fl_ptr_t                              head, tail, rd_ptr, wr_ptr;
    logic [INST_DECODE_NUM-1:0]           slot_vld, consume, need, fill_go;
    phy_reg_id_t [INST_DECODE_NUM-1:0]    slot_id, fill_id;
    logic [INST_DECODE_NUM-1:0][LANE_CNT_W-1:0] need_off;
    logic [LANE_CNT_W-1:0]                need_cnt;
    logic [RELEASE_NUM-1:0]               rel_ok, rel_bad, rel_acc;
    logic [RELEASE_NUM-1:0][REL_CNT_W-1:0] rel_off;
    logic [REL_CNT_W-1:0]                 rel_cnt;
    logic [RELEASE_NUM-1:0][FL_IDX_W-1:0] wr_idx;
    cnt_t                                 fill_n, kept, room, rel_n;
    logic                                 overflow;

    assign v_pre_allocate_vld = slot_vld;
    assign v_pre_allocate_id  = slot_id;
    assign consume = slot_vld & v_pre_allocate_rdy & ~v_pre_allocate_zero;
    assign need    = ~slot_vld | consume;

    toy_phy_reg_freelist_compact #(.N(INST_DECODE_NUM), .W(LANE_CNT_W)) u_fill_compact (
        .req (need),
        .off (need_off),
        .cnt (need_cnt)
    );

    toy_phy_reg_freelist_compact #(.N(RELEASE_NUM), .W(REL_CNT_W)) u_rel_compact (
        .req (rel_ok),
        .off (rel_off),
        .cnt (rel_cnt)
    );

    // Room counts IDs still held in slots, so releases can never push FIFO + slots past FL_DEPTH.
    always_comb begin
        fill_n = (cnt_t'(need_cnt) < free_cnt) ? cnt_t'(need_cnt) : free_cnt;
        kept   = '0;
        rd_ptr = head;
        for (int i = 0; i < INST_DECODE_NUM; i++) begin
            rd_ptr     = ptr_add(head, cnt_t'(need_off[i]));
            fill_id[i] = fifo[rd_ptr.idx];
            fill_go[i] = need[i] & (cnt_t'(need_off[i]) < fill_n);
            kept       = kept + cnt_t'(slot_vld[i] & ~consume[i]);
        end
        room     = FL_DEPTH_C - free_cnt - kept;
        rel_n    = (cnt_t'(rel_cnt) < room) ? cnt_t'(rel_cnt) : room;
        overflow = cnt_t'(rel_cnt) > room;
        wr_ptr   = tail;
        for (int j = 0; j < RELEASE_NUM; j++) begin
            rel_acc[j] = rel_ok[j] & (cnt_t'(rel_off[j]) < room);
            wr_ptr     = ptr_add(tail, cnt_t'(rel_off[j]));
            wr_idx[j]  = wr_ptr.idx;
        end
    end

`ifdef TOY_FREELIST_CHECK_EN
    logic [PHY_REG_NUM-1:0] free_map;
    logic [RELEASE_NUM-1:0] dup;

    always_comb begin
        dup     = '0;
        rel_bad = '0;
        for (int j = 0; j < RELEASE_NUM; j++) begin
            for (int k = 0; k < RELEASE_NUM; k++)
                if (k != j)
                    dup[j] = dup[j] | (v_release_vld[k] & (v_release_id[k] == v_release_id[j]));
            rel_bad[j] = v_release_vld[j] &
                         (free_map[v_release_id[j]] | (v_release_id[j] < ARCH_ID) | dup[j]);
        end
        rel_ok = v_release_vld & ~rel_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_map <= {{(PHY_REG_NUM-ARCH_REG_NUM){1'b1}}, {ARCH_REG_NUM{1'b0}}};
        end else begin
            for (int i = 0; i < INST_DECODE_NUM; i++)
                if (fill_go[i]) free_map[fill_id[i]] <= 1'b0;
            for (int j = 0; j < RELEASE_NUM; j++)
                if (rel_acc[j]) free_map[v_release_id[j]] <= 1'b1;
        end
    end
`else
    assign rel_bad = '0;
    assign rel_ok  = v_release_vld;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FL_DEPTH; k++)
                fifo[k] <= phy_reg_id_t'(ARCH_REG_NUM + k);
            head         <= '0;
            tail         <= '{wrap: 1'b1, idx: '0};
            free_cnt     <= FL_DEPTH_C;
            slot_vld     <= '0;
            slot_id      <= '0;
            freelist_err <= 1'b0;
        end else begin
            head         <= ptr_add(head, fill_n);
            tail         <= ptr_add(tail, rel_n);
            free_cnt     <= free_cnt - fill_n + rel_n;
            freelist_err <= freelist_err | overflow | (|rel_bad);
            for (int j = 0; j < RELEASE_NUM; j++)
                if (rel_acc[j]) fifo[wr_idx[j]] <= v_release_id[j];
            for (int i = 0; i < INST_DECODE_NUM; i++)
                if (need[i]) begin
                    slot_vld[i] <= fill_go[i];
                    if (fill_go[i]) slot_id[i] <= fill_id[i];
                end
        end
    end

endmodule
